float_mul_pipe: RTL and testbench



---
 rtl/float_pkg.sv | 25 ++
 rtl/float_round_pack.sv | 54 +++++
 rtl/float_mul_pipe.sv | 169 ++++++++++++++++
 tb/tb_float_mul_pipe.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared format constants and field helpers for the small floating-point datapath.
// Encoding: {sign, biased exponent, fraction}; exponent code 0 is zero, no Inf/NaN.
package float_pkg;

  localparam int unsigned DEF_EXP_W = 7;
  localparam int unsigned DEF_MAN_W = 16;
  localparam int unsigned DEF_BIAS  = (2 ** (DEF_EXP_W - 1)) - 1;
  localparam int unsigned DEF_W     = 1 + DEF_EXP_W + DEF_MAN_W;

  localparam logic [DEF_EXP_W-1:0] EXP_MAX   = '1;
  localparam logic [DEF_W-1:0]     ZERO_WORD = '0;

  function automatic logic sign_of(input logic [DEF_W-1:0] f);
    return f[DEF_W-1];
  endfunction

  function automatic logic [DEF_EXP_W-1:0] exp_of(input logic [DEF_W-1:0] f);
    return f[DEF_W-2 -: DEF_EXP_W];
  endfunction

  function automatic logic [DEF_MAN_W-1:0] man_of(input logic [DEF_W-1:0] f);
    return f[DEF_MAN_W-1:0];
  endfunction

endpackage

// File: rtl/float_round_pack.sv
// Combinational round/renormalise/saturate/pack stage shared by float arithmetic units.
// man_i carries a normalised significand with the hidden one at its top bit.
module float_round_pack
  import float_pkg::*;
#(
  parameter int unsigned EXP_W = DEF_EXP_W,
  parameter int unsigned MAN_W = DEF_MAN_W
) (
  input  logic                   sign_i,
  input  logic                   zero_i,
  input  logic                   rnd_i,
  input  logic [EXP_W+1:0]       exp_i,
  input  logic [2*MAN_W:0]       man_i,
  output logic [EXP_W+MAN_W:0]   word_o,
  output logic                   ovf_o,
  output logic                   udf_o
);

  logic [MAN_W-1:0] frac;
  logic             guard;
  logic             sticky;
  logic             inc;
  logic [MAN_W:0]   frac_sum;
  logic [EXP_W+1:0] exp_r;
  logic             is_ovf;
  logic             is_udf;

  always_comb begin
    frac     = man_i[2*MAN_W-1:MAN_W];
    guard    = man_i[MAN_W-1];
    sticky   = |man_i[MAN_W-2:0];
    inc      = rnd_i & guard & (sticky | frac[0]);
    frac_sum = {1'b0, frac} + {{MAN_W{1'b0}}, inc};
    // A carry out leaves the fraction at zero and bumps the exponent.
    exp_r    = exp_i + {{(EXP_W + 1){1'b0}}, frac_sum[MAN_W]};
    // exp_r is two's complement and never reaches 2**(EXP_W+1), so bit EXP_W flags overflow.
    is_ovf   = ~exp_r[EXP_W+1] & exp_r[EXP_W];
    is_udf   = exp_r[EXP_W+1] | (exp_r == '0);

    word_o = {sign_i, exp_r[EXP_W-1:0], frac_sum[MAN_W-1:0]};
    ovf_o  = 1'b0;
    udf_o  = 1'b0;
    if (zero_i) begin
      word_o = {sign_i, {(EXP_W + MAN_W){1'b0}}};
    end else if (is_ovf) begin
      word_o = {sign_i, {(EXP_W + MAN_W){1'b1}}};
      ovf_o  = 1'b1;
    end else if (is_udf) begin
      word_o = {sign_i, {(EXP_W + MAN_W){1'b0}}};
      udf_o  = 1'b1;
    end
  end

endmodule

// File: rtl/float_mul_pipe.sv
// Three-stage pipelined float multiplier with valid/ready flow control and rounding select.
// rst is asynchronous and active-low; a stalled output stalls the whole pipe.
module float_mul_pipe
  import float_pkg::*;
#(
  parameter int unsigned EXP_W = DEF_EXP_W,
  parameter int unsigned MAN_W = DEF_MAN_W,
  parameter int unsigned BIAS  = (2 ** (EXP_W - 1)) - 1,
  localparam int unsigned W    = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         round_mode,
  input  logic [W-1:0] float_a,
  input  logic [W-1:0] float_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] float_out,
  output logic         float_out_overflow,
  output logic         float_out_underflow
);

  localparam int unsigned EW = EXP_W + 2;
  localparam int unsigned MW = MAN_W + 1;
  localparam int unsigned PW = 2 * MW;
  localparam int unsigned NW = PW - 1;

  logic ce;
  logic s1_load, s2_load, s3_load;

  logic          s1_valid_d, s1_valid_q;
  logic          s1_zero_d, s1_zero_q;
  logic          s1_sign_d, s1_sign_q;
  logic          s1_rnd_d, s1_rnd_q;
  logic [EW-1:0] s1_exp_d, s1_exp_q;
  logic [MW-1:0] s1_man_a_d, s1_man_a_q;
  logic [MW-1:0] s1_man_b_d, s1_man_b_q;

  logic [PW-1:0] prod;
  logic          s2_valid_d, s2_valid_q;
  logic          s2_zero_d, s2_zero_q;
  logic          s2_sign_d, s2_sign_q;
  logic          s2_rnd_d, s2_rnd_q;
  logic [EW-1:0] s2_exp_d, s2_exp_q;
  logic [NW-1:0] s2_man_d, s2_man_q;

  logic         s3_valid_d, s3_valid_q;
  logic [W-1:0] s3_word_d, s3_word_q;
  logic         s3_ovf_d, s3_ovf_q;
  logic         s3_udf_d, s3_udf_q;

  always_comb begin
    ce       = ~s3_valid_q | out_ready;
    in_ready = ce;
    s1_load  = ce & in_valid;
    s2_load  = ce & s1_valid_q;
    s3_load  = ce & s2_valid_q;
  end

  // S1: unpack, zero detect, sign and biased exponent sum.
  always_comb begin
    s1_valid_d = ce ? in_valid : s1_valid_q;
    s1_zero_d  = (float_a[W-2 -: EXP_W] == '0) | (float_b[W-2 -: EXP_W] == '0);
    s1_sign_d  = float_a[W-1] ^ float_b[W-1];
    s1_rnd_d   = round_mode;
    s1_exp_d   = {2'b00, float_a[W-2 -: EXP_W]} + {2'b00, float_b[W-2 -: EXP_W]} - EW'(BIAS);
    s1_man_a_d = {1'b1, float_a[MAN_W-1:0]};
    s1_man_b_d = {1'b1, float_b[MAN_W-1:0]};
  end

  // S2: significand product, normalised to a single leading one.
  always_comb begin
    prod       = {{MW{1'b0}}, s1_man_a_q} * {{MW{1'b0}}, s1_man_b_q};
    s2_valid_d = ce ? s1_valid_q : s2_valid_q;
    s2_zero_d  = s1_zero_q;
    s2_sign_d  = s1_sign_q;
    s2_rnd_d   = s1_rnd_q;
    s2_exp_d   = s1_exp_q + {{(EW - 1){1'b0}}, prod[PW-1]};
    // The bit shifted out is folded into bit 0 so it still counts toward sticky.
    s2_man_d   = prod[PW-1] ? {prod[PW-1:2], prod[1] | prod[0]} : prod[PW-2:0];
  end

  float_round_pack #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round_pack (
    .sign_i (s2_sign_q),
    .zero_i (s2_zero_q),
    .rnd_i  (s2_rnd_q),
    .exp_i  (s2_exp_q),
    .man_i  (s2_man_q),
    .word_o (s3_word_d),
    .ovf_o  (s3_ovf_d),
    .udf_o  (s3_udf_d)
  );

  always_comb begin
    s3_valid_d = ce ? s2_valid_q : s3_valid_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s3_valid_q <= s3_valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_zero_q  <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_rnd_q   <= 1'b0;
      s1_exp_q   <= '0;
      s1_man_a_q <= '0;
      s1_man_b_q <= '0;
    end else if (s1_load) begin
      s1_zero_q  <= s1_zero_d;
      s1_sign_q  <= s1_sign_d;
      s1_rnd_q   <= s1_rnd_d;
      s1_exp_q   <= s1_exp_d;
      s1_man_a_q <= s1_man_a_d;
      s1_man_b_q <= s1_man_b_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_zero_q <= 1'b0;
      s2_sign_q <= 1'b0;
      s2_rnd_q  <= 1'b0;
      s2_exp_q  <= '0;
      s2_man_q  <= '0;
    end else if (s2_load) begin
      s2_zero_q <= s2_zero_d;
      s2_sign_q <= s2_sign_d;
      s2_rnd_q  <= s2_rnd_d;
      s2_exp_q  <= s2_exp_d;
      s2_man_q  <= s2_man_d;
    end
  end

  // Output data only moves on a real result, so it holds through bubbles and stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s3_word_q <= '0;
      s3_ovf_q  <= 1'b0;
      s3_udf_q  <= 1'b0;
    end else if (s3_load) begin
      s3_word_q <= s3_word_d;
      s3_ovf_q  <= s3_ovf_d;
      s3_udf_q  <= s3_udf_d;
    end
  end

  always_comb begin
    out_valid           = s3_valid_q;
    float_out           = s3_word_q;
    float_out_overflow  = s3_ovf_q;
    float_out_underflow = s3_udf_q;
  end

endmodule

// File: tb/tb_float_mul_pipe.sv
// Scoreboard bench for float_mul_pipe: exact-arithmetic reference model, directed corner
// vectors, random traffic with random backpressure, stall hold and mid-stream reset.
module tb_float_mul_pipe;
  import float_pkg::*;

  typedef struct {
    logic [23:0] word;
    logic        ovf;
    logic        udf;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        round_mode = 1'b0;
  logic [23:0] float_a = '0;
  logic [23:0] float_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] float_out;
  logic        float_out_overflow;
  logic        float_out_underflow;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   lat_chk = 1'b0;
  bit   rand_done = 1'b0;
  exp_t sb[$];

  float_mul_pipe dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .round_mode          (round_mode),
    .float_a             (float_a),
    .float_b             (float_b),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .float_out           (float_out),
    .float_out_overflow  (float_out_overflow),
    .float_out_underflow (float_out_underflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Reference: exact integer product, rounded from the true remainder.
  function automatic exp_t model(input logic [23:0] a, input logic [23:0] b, input logic rnd);
    exp_t   r;
    logic   s;
    longint p, q, rem, half;
    int     e, sh;
    s = sign_of(a) ^ sign_of(b);
    r.word = ZERO_WORD;
    r.word[23] = s;
    r.ovf = 1'b0;
    r.udf = 1'b0;
    r.acc = 0;
    if (exp_of(a) == 0 || exp_of(b) == 0) return r;
    p  = longint'({1'b1, man_of(a)}) * longint'({1'b1, man_of(b)});
    e  = int'(exp_of(a)) + int'(exp_of(b)) - int'(DEF_BIAS);
    sh = DEF_MAN_W;
    if (p >= (longint'(1) << (2 * DEF_MAN_W + 1))) begin
      sh = sh + 1;
      e  = e + 1;
    end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = longint'(1) << (sh - 1);
    if (rnd && (rem > half || (rem == half && (q % 2) == 1))) q = q + 1;
    if (q == (longint'(1) << (DEF_MAN_W + 1))) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e > int'(EXP_MAX)) begin
      r.word = {s, 23'h7FFFFF};
      r.ovf  = 1'b1;
    end else if (e < 1) begin
      r.udf = 1'b1;
    end else begin
      r.word = {s, 7'(e), 16'(q)};
    end
    return r;
  endfunction

  function automatic logic [23:0] rand_word();
    logic [23:0] w;
    w = 24'($urandom);
    // Zero the low fraction half the time so ties and exact products show up often.
    if ($urandom_range(0, 1) == 1) w[11:0] = 12'h000;
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [23:0] a, input logic [23:0] b, input logic rnd,
                       input exp_t e);
    int n;
    n = 0;
    in_valid   = 1'b1;
    float_a    = a;
    float_b    = b;
    round_mode = rnd;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: in_ready stayed %0b, expected 1", in_ready);
    end else begin
      e.acc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic issue_model(input logic [23:0] a, input logic [23:0] b, input logic rnd);
    issue(a, b, rnd, model(a, b, rnd));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: pops the scoreboard on every transfer, checks hold under stall.
  logic        held = 1'b0;
  logic [25:0] held_val = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      held = 1'b0;
    end else begin
      chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (held) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_hold", 32'({float_out, float_out_overflow, float_out_underflow}),
            32'(held_val));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 32'(float_out), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("result", 32'({float_out, float_out_overflow, float_out_underflow}),
              32'({e.word, e.ovf, e.udf}));
          if (lat_chk) chk("latency", 32'(cyc - e.acc), 32'd3);
        end
      end
      held     = out_valid && !out_ready;
      held_val = {float_out, float_out_overflow, float_out_underflow};
    end
  end

  logic [23:0] da[8];
  logic [23:0] db[8];
  logic [23:0] dw[8];
  logic        dr[8];
  logic        dov[8];
  logic        dun[8];

  initial begin
    exp_t e;
    da  = '{24'h469040, 24'h3754C9, 24'h7F0000, 24'h010000,
            24'h000000, 24'h800000, 24'h3F0001, 24'h3F0001};
    db  = '{24'h3D8000, 24'h470000, 24'h400000, 24'h810000,
            24'h3E0000, 24'h7F0000, 24'h3F8000, 24'h3F8000};
    dw  = '{24'h452C30, 24'h3F54C9, 24'h7FFFFF, 24'h800000,
            24'h000000, 24'h800000, 24'h3F8002, 24'h3F8001};
    dr  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    dov = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    dun = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_float_out", 32'(float_out), 32'd0);
    chk("rst_flags", 32'({float_out_overflow, float_out_underflow}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed corners streamed back to back with a free-running consumer.
    lat_chk = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e.word = dw[i];
      e.ovf  = dov[i];
      e.udf  = dun[i];
      e.acc  = 0;
      issue(da[i], db[i], dr[i], e);
    end
    drain();
    lat_chk = 1'b0;

    // Random traffic with random bubbles and backpressure.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          issue_model(rand_word(), rand_word(), 1'($urandom_range(0, 1)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Full stall: five pairs against a blocked consumer, then release.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) issue_model(rand_word(), rand_word(), 1'b1);
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset while results are in flight: they are discarded.
    for (int i = 0; i < 4; i++) issue_model(rand_word(), rand_word(), 1'b1);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_out", 32'({float_out, float_out_overflow, float_out_underflow}), 32'd0);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    issue_model(24'h3F0001, 24'h3F8000, 1'b0);
    for (int i = 0; i < 3; i++) issue_model(rand_word(), rand_word(), 1'b1);
    drain();
    repeat (5) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
